program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer_if.sv | 35 +++
 rtl/program_sequencer.sv | 97 +++++++++
 tb/tb_program_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/program_sequencer_if.sv
// Control and status bundle for program_sequencer: the master drives
// control-flow requests, the sequencer returns its program address and stack status.
interface program_sequencer_if #(
    parameter int AW    = 12,
    parameter int DEPTH = 8
);
    localparam int DW = $clog2(DEPTH) + 1;

    // Controls are level inputs sampled on every rising clk; there is no
    // valid/ready pair, so the request present at an edge is the request taken.
    logic          no_inc;
    logic          jmp;
    logic [AW-1:0] jmp_addr;
    logic          br;
    logic [AW-1:0] br_off;
    logic          call;
    logic          ret;

    logic [AW-1:0] addr_out;
    logic [DW-1:0] depth;
    logic          stack_full;
    logic          stack_empty;
    logic          ovf_err;
    logic          unf_err;

    modport master (
        output no_inc, jmp, jmp_addr, br, br_off, call, ret,
        input  addr_out, depth, stack_full, stack_empty, ovf_err, unf_err
    );

    modport slave (
        input  no_inc, jmp, jmp_addr, br, br_off, call, ret,
        output addr_out, depth, stack_full, stack_empty, ovf_err, unf_err
    );
endinterface

// File: rtl/program_sequencer.sv
// Program address sequencer: sequential/hold, absolute jump, relative branch,
// and call/return through a fixed-depth return stack with sticky error flags.
module program_sequencer #(
    parameter int          AW         = 12,
    parameter int          DEPTH      = 8,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic               clk,
    input  logic               reset,
    program_sequencer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;

    typedef enum logic [2:0] {
        ACT_SEQ,
        ACT_HOLD,
        ACT_BR,
        ACT_JMP,
        ACT_CALL,
        ACT_CALL_OVF,
        ACT_RET,
        ACT_RET_UNF
    } action_t;

    logic [AW-1:0] stack_mem [DEPTH];
    logic [AW-1:0] addr_q, addr_nxt;
    logic [DW-1:0] depth_q, depth_nxt;
    logic          ovf_q, unf_q;
    logic          full, empty;
    logic [AW-1:0] ret_addr, top_entry;
    action_t       act;

    assign full      = (depth_q == DW'(DEPTH));
    assign empty     = (depth_q == '0);
    assign ret_addr  = addr_q + AW'(1);
    assign top_entry = stack_mem[PW'(depth_q - DW'(1))];

    // Priority ret > call > jmp > br > sequential; error cases still win.
    always_comb begin
        act = bus.no_inc ? ACT_HOLD : ACT_SEQ;
        if (bus.ret)
            act = empty ? ACT_RET_UNF : ACT_RET;
        else if (bus.call)
            act = full ? ACT_CALL_OVF : ACT_CALL;
        else if (bus.jmp)
            act = ACT_JMP;
        else if (bus.br)
            act = ACT_BR;
    end

    always_comb begin
        addr_nxt  = addr_q;
        depth_nxt = depth_q;
        case (act)
            ACT_SEQ:  addr_nxt = ret_addr;
            ACT_BR:   addr_nxt = addr_q + bus.br_off;
            ACT_JMP:  addr_nxt = bus.jmp_addr;
            ACT_CALL: begin
                addr_nxt  = bus.jmp_addr;
                depth_nxt = depth_q + DW'(1);
            end
            ACT_RET: begin
                addr_nxt  = top_entry;
                depth_nxt = depth_q - DW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= AW'(RESET_ADDR);
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_nxt;
            depth_q <= depth_nxt;
            ovf_q   <= ovf_q | (act == ACT_CALL_OVF);
            unf_q   <= unf_q | (act == ACT_RET_UNF);
        end
    end

    // Entries are never cleared: with depth at 0 nothing can read them.
    always_ff @(posedge clk) begin
        if (act == ACT_CALL)
            stack_mem[PW'(depth_q)] <= ret_addr;
    end

    assign bus.addr_out    = addr_q;
    assign bus.depth       = depth_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.ovf_err     = ovf_q;
    assign bus.unf_err     = unf_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a driver queues the expected post-edge
// outputs, a monitor pops and compares them after every rising edge.
module tb_program_sequencer;
    localparam int AW    = 12;
    localparam int DEPTH = 8;
    localparam int W     = AW + 4 + 4;

    logic clk;
    logic reset;

    program_sequencer_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    program_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           n_vec  = 0;
    int           n_err  = 0;
    int           vec_id = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pk(input logic [AW-1:0] a, input logic [3:0] d,
                                        input logic ovf, input logic unf);
        return {a, d, (d == 4'd8), (d == 4'd0), ovf, unf};
    endfunction

    function automatic logic [W-1:0] actual();
        return {bus.addr_out, bus.depth, bus.stack_full, bus.stack_empty,
                bus.ovf_err, bus.unf_err};
    endfunction

    task automatic compare(input string name, input int tag, input logic [W-1:0] e);
        logic [W-1:0] a;
        a = actual();
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s #%0d: got addr=%h depth=%0d full=%b empty=%b ovf=%b unf=%b, want addr=%h depth=%0d full=%b empty=%b ovf=%b unf=%b",
                     name, tag, a[W-1 -: AW], a[7:4], a[3], a[2], a[1], a[0],
                     e[W-1 -: AW], e[7:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] e);
        exp_q.push_back(e);
        tag_q.push_back(vec_id);
        vec_id++;
    endtask

    task automatic clear_ctl();
        bus.no_inc = 1'b0; bus.jmp = 1'b0; bus.jmp_addr = '0;
        bus.br = 1'b0; bus.br_off = '0; bus.call = 1'b0; bus.ret = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic ni, input logic j, input logic [AW-1:0] ja,
                         input logic b, input logic [AW-1:0] bo,
                         input logic c, input logic r, input logic [W-1:0] e);
        @(negedge clk);
        bus.no_inc = ni; bus.jmp = j; bus.jmp_addr = ja;
        bus.br = b; bus.br_off = bo; bus.call = c; bus.ret = r;
        push_exp(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                compare("edge", tag_q.pop_front(), exp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a;
        int            k;
        clear_ctl();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 compare("reset_async", -1, pk(12'h000, 4'd0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1 compare("reset_held", -1, pk(12'h000, 4'd0, 1'b0, 1'b0));

        // Release; the first edge after release is a normal sequential step.
        @(negedge clk);
        reset = 1'b1;
        push_exp(pk(12'h001, 4'd0, 1'b0, 1'b0));
        for (int i = 2; i <= 5; i++)
            drive(0, 0, 0, 0, 0, 0, 0, pk(AW'(i), 4'd0, 1'b0, 1'b0));
        drive(1, 0, 0, 0, 0, 0, 0, pk(12'h005, 4'd0, 1'b0, 1'b0));
        drive(1, 0, 0, 0, 0, 0, 0, pk(12'h005, 4'd0, 1'b0, 1'b0));

        // Branches wrap both ways; no_inc does not block a branch.
        drive(0, 1, 12'h002, 0, 0,       0, 0, pk(12'h002, 4'd0, 1'b0, 1'b0));
        drive(0, 0, 0,       1, 12'hFFC, 0, 0, pk(12'hFFE, 4'd0, 1'b0, 1'b0));
        drive(0, 0, 0,       0, 0,       0, 0, pk(12'hFFF, 4'd0, 1'b0, 1'b0));
        drive(0, 0, 0,       0, 0,       0, 0, pk(12'h000, 4'd0, 1'b0, 1'b0));
        drive(0, 0, 0,       1, 12'h010, 0, 0, pk(12'h010, 4'd0, 1'b0, 1'b0));
        drive(1, 0, 0,       1, 12'h005, 0, 0, pk(12'h015, 4'd0, 1'b0, 1'b0));
        drive(0, 1, 12'h123, 1, 12'h005, 0, 0, pk(12'h123, 4'd0, 1'b0, 1'b0));

        // Call / return; return address is addr+1 even with no_inc set.
        drive(0, 1, 12'h0FF, 0, 0, 0, 0, pk(12'h0FF, 4'd0, 1'b0, 1'b0));
        drive(0, 0, 12'h400, 0, 0, 1, 0, pk(12'h400, 4'd1, 1'b0, 1'b0));
        drive(0, 0, 0,       0, 0, 0, 1, pk(12'h100, 4'd0, 1'b0, 1'b0));
        drive(1, 0, 12'h200, 0, 0, 1, 0, pk(12'h200, 4'd1, 1'b0, 1'b0));
        drive(1, 0, 0,       0, 0, 0, 1, pk(12'h101, 4'd0, 1'b0, 1'b0));

        // Underflow, then ret+call+jmp together at depth 1.
        drive(0, 0, 0,       0, 0, 0, 1, pk(12'h101, 4'd0, 1'b0, 1'b1));
        drive(0, 0, 12'h300, 0, 0, 1, 0, pk(12'h300, 4'd1, 1'b0, 1'b1));
        drive(0, 1, 12'h777, 0, 0, 1, 1, pk(12'h102, 4'd0, 1'b0, 1'b1));

        // Fill the stack, overflow with jmp also asserted, then unwind LIFO.
        drive(0, 1, 12'h010, 0, 0, 0, 0, pk(12'h010, 4'd0, 1'b0, 1'b1));
        for (int i = 0; i < 8; i++) begin
            a = AW'((i + 1) * 12'h100);
            drive(0, 0, a, 0, 0, 1, 0, pk(a, 4'(i + 1), 1'b0, 1'b1));
        end
        drive(0, 1, 12'h900, 0, 0, 1, 0, pk(12'h800, 4'd8, 1'b1, 1'b1));
        for (int j = 0; j < 8; j++) begin
            k = 7 - j;
            a = (k == 0) ? 12'h011 : AW'(k * 12'h100 + 1);
            drive(0, 0, 0, 0, 0, 0, 1, pk(a, 4'(7 - j), 1'b1, 1'b1));
        end

        // Reset asserted between edges while a call is pending.
        drive(0, 1, 12'h050, 0, 0, 0, 0, pk(12'h050, 4'd0, 1'b1, 1'b1));
        drive(0, 0, 12'h600, 0, 0, 1, 0, pk(12'h600, 4'd1, 1'b1, 1'b1));
        @(negedge clk);
        bus.call = 1'b1; bus.jmp_addr = 12'hABC; bus.no_inc = 1'b0;
        #2 reset = 1'b0;
        #1 compare("reset_mid_call", -2, pk(12'h000, 4'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1 compare("reset_edge", -3, pk(12'h000, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        clear_ctl();
        reset = 1'b1;
        push_exp(pk(12'h001, 4'd0, 1'b0, 1'b0));
        drive(0, 0, 0, 0, 0, 0, 1, pk(12'h001, 4'd0, 1'b0, 1'b1));
        drive(0, 0, 0, 0, 0, 0, 0, pk(12'h002, 4'd0, 1'b0, 1'b1));

        // Drain the scoreboard within a bounded number of cycles.
        @(negedge clk);
        clear_ctl();
        for (int c = 0; c < 10 && exp_q.size() > 0; c++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
